// File: rtl/riscv_alu_mult_serial_pkg.sv
// -----------------------------------------------------------------------------
// riscv_alu_mult_pkg
// Shared types and sizing constants for the serial RV32M multiplier.
//   mult_op_t    : opcode as carried on OpCode_SI (MUL, MULH, MULHSU, MULHU)
//   mult_state_t : control FSM states (IDLE, MULT, FINISH)
//   C_MULT_WIDTH / C_MULT_LOG_WIDTH : default operand width and counter width
// -----------------------------------------------------------------------------
package riscv_alu_mult_pkg;

    localparam int unsigned C_MULT_WIDTH     = 32;
    localparam int unsigned C_MULT_LOG_WIDTH = 6;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

endpackage : riscv_alu_mult_pkg

// File: rtl/riscv_alu_mult_serial_if.sv
// -----------------------------------------------------------------------------
// riscv_alu_mult_serial_if
// Operand/result bus of the serial multiplier, same shape as the divider bus.
//   OpA_DI, OpB_DI : operands (rs1, rs2)
//   OpCode_SI      : mult_op_t encoding
//   InVld_SI / InRdy_SO   : operand handshake
//   OutVld_SO / OutRdy_SI : result handshake
//   Res_DO         : selected product half
// Modports: master = EX stage side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface riscv_alu_mult_serial_if
    import riscv_alu_mult_pkg::*;
#(
    parameter int unsigned C_WIDTH = C_MULT_WIDTH
);
    logic [C_WIDTH-1:0] OpA_DI;
    logic [C_WIDTH-1:0] OpB_DI;
    logic [1:0]         OpCode_SI;
    logic               InVld_SI;
    logic               InRdy_SO;
    logic               OutRdy_SI;
    logic               OutVld_SO;
    logic [C_WIDTH-1:0] Res_DO;

    modport master (
        output OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
        input  InRdy_SO, OutVld_SO, Res_DO
    );

    modport slave (
        input  OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
        output InRdy_SO, OutVld_SO, Res_DO
    );

endinterface : riscv_alu_mult_serial_if

// File: rtl/riscv_alu_mult_serial_sign_conv.sv
// -----------------------------------------------------------------------------
// riscv_alu_mult_sign_conv
// Conditional two's-complement negation, used for operand magnitudes and for
// re-applying the result sign over the full double-width product.
//   Neg_SI  : negate when high
//   Data_DI : input value
//   Data_DO : Neg_SI ? -Data_DI : Data_DI
// -----------------------------------------------------------------------------
module riscv_alu_mult_sign_conv #(
    parameter int unsigned C_WIDTH = 32
) (
    input  logic               Neg_SI,
    input  logic [C_WIDTH-1:0] Data_DI,
    output logic [C_WIDTH-1:0] Data_DO
);

    // Negate or pass through; the most negative value maps onto itself, which
    // read as unsigned is exactly its magnitude.
    always_comb begin
        if (Neg_SI) begin
            Data_DO = (~Data_DI) + C_WIDTH'(1);
        end else begin
            Data_DO = Data_DI;
        end
    end

endmodule : riscv_alu_mult_sign_conv

// File: rtl/riscv_alu_mult_serial.sv
// -----------------------------------------------------------------------------
// riscv_alu_mult_serial
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one partial product
// per cycle. Operands are converted to magnitudes at accept, multiplied
// unsigned, and the sign is re-applied to the 2*C_WIDTH product at the output.
// Ports:
//   Clk_CI : clock
//   Rst_RI : synchronous active-high reset
//   Bus_S  : riscv_alu_mult_serial_if.slave (operands, opcode, handshakes, result)
// Build options:
//   MULT_ZERO_BYPASS_EN : a zero operand skips MULT and finishes in one cycle.
//   ASSERT              : elaboration check of C_LOG_WIDTH against C_WIDTH.
// -----------------------------------------------------------------------------
module riscv_alu_mult_serial
    import riscv_alu_mult_pkg::*;
#(
    parameter int unsigned C_WIDTH     = C_MULT_WIDTH,
    parameter int unsigned C_LOG_WIDTH = C_MULT_LOG_WIDTH
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    riscv_alu_mult_serial_if.slave Bus_S
);

    mult_state_t              state_r;
    mult_state_t              nextState_s;
    logic [C_WIDTH-1:0]       acc_r;
    logic [C_WIDTH-1:0]       q_r;
    logic [C_WIDTH-1:0]       b_r;
    logic [C_LOG_WIDTH-1:0]   cnt_r;
    logic                     resInv_r;
    logic                     hiSel_r;

    mult_op_t                 op_s;
    logic                     signA_s;
    logic                     signB_s;
    logic [C_WIDTH-1:0]       magA_s;
    logic [C_WIDTH-1:0]       magB_s;
    logic                     accept_s;
    logic                     zeroByp_s;
    logic [C_WIDTH:0]         sum_s;
    logic [2*C_WIDTH-1:0]     prodF_s;
    logic                     inRdy_s;
    logic                     outVld_s;

`ifdef ASSERT
    generate
        if (C_LOG_WIDTH != $clog2(C_WIDTH + 1)) begin : gen_bad_log_width
            $error("riscv_alu_mult_serial: C_LOG_WIDTH must equal $clog2(C_WIDTH+1)");
        end
    endgenerate
`endif

    assign op_s     = mult_op_t'(Bus_S.OpCode_SI);
    assign accept_s = (state_r == IDLE) & Bus_S.InVld_SI;

    // MUL takes both operands as signed; its low word is sign-agnostic anyway.
    assign signA_s = Bus_S.OpA_DI[C_WIDTH-1] & (op_s != MULHU);
    assign signB_s = Bus_S.OpB_DI[C_WIDTH-1] & ((op_s == MULH) | (op_s == MUL));

    riscv_alu_mult_sign_conv #(.C_WIDTH(C_WIDTH)) i_conv_a (
        .Neg_SI  (signA_s),
        .Data_DI (Bus_S.OpA_DI),
        .Data_DO (magA_s)
    );

    riscv_alu_mult_sign_conv #(.C_WIDTH(C_WIDTH)) i_conv_b (
        .Neg_SI  (signB_s),
        .Data_DI (Bus_S.OpB_DI),
        .Data_DO (magB_s)
    );

`ifdef MULT_ZERO_BYPASS_EN
    assign zeroByp_s = (magA_s == '0) | (magB_s == '0);
`else
    assign zeroByp_s = 1'b0;
`endif

    // One partial-product add; the carry-out is kept and shifted into Acc.
    always_comb begin
        if (q_r[0]) begin
            sum_s = {1'b0, acc_r} + {1'b0, b_r};
        end else begin
            sum_s = {1'b0, acc_r};
        end
    end

    // FSM state register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (Bus_S.InVld_SI) begin
                    nextState_s = zeroByp_s ? FINISH : MULT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            MULT: begin
                if (cnt_r == '0) begin
                    nextState_s = FINISH;
                end else begin
                    nextState_s = MULT;
                end
            end
            FINISH: begin
                if (Bus_S.OutRdy_SI) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = FINISH;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the state register.
    always_comb begin
        inRdy_s  = 1'b0;
        outVld_s = 1'b0;
        case (state_r)
            IDLE:    inRdy_s  = 1'b1;
            MULT:    inRdy_s  = 1'b0;
            FINISH:  outVld_s = 1'b1;
            default: inRdy_s  = 1'b0;
        endcase
    end

    // Datapath: load magnitudes on accept, shift-add while in MULT, hold otherwise.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            acc_r    <= '0;
            q_r      <= '0;
            b_r      <= '0;
            cnt_r    <= '0;
            resInv_r <= 1'b0;
            hiSel_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r   <= '0;
                        b_r     <= magB_s;
                        cnt_r   <= C_LOG_WIDTH'(C_WIDTH - 1);
                        hiSel_r <= (op_s != MUL);
                        if (zeroByp_s) begin
                            q_r      <= '0;
                            resInv_r <= 1'b0;
                        end else begin
                            q_r      <= magA_s;
                            resInv_r <= signA_s ^ signB_s;
                        end
                    end
                end
                MULT: begin
                    {acc_r, q_r} <= {sum_s, q_r[C_WIDTH-1:1]};
                    cnt_r        <= cnt_r - C_LOG_WIDTH'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    riscv_alu_mult_sign_conv #(.C_WIDTH(2 * C_WIDTH)) i_conv_p (
        .Neg_SI  (resInv_r),
        .Data_DI ({acc_r, q_r}),
        .Data_DO (prodF_s)
    );

    assign Bus_S.InRdy_SO  = inRdy_s;
    assign Bus_S.OutVld_SO = outVld_s;
    assign Bus_S.Res_DO    = hiSel_r ? prodF_s[2*C_WIDTH-1:C_WIDTH] : prodF_s[C_WIDTH-1:0];

endmodule : riscv_alu_mult_serial

// File: tb/tb_riscv_alu_mult_serial.sv
// -----------------------------------------------------------------------------
// tb_riscv_alu_mult_serial
// Self-checking bench for riscv_alu_mult_serial. Expected results come from a
// 64-bit arithmetic model of the RV32M multiply instructions; expected latency
// depends on whether MULT_ZERO_BYPASS_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_riscv_alu_mult_serial;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    riscv_alu_mult_serial_if bus ();

    riscv_alu_mult_serial dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .Bus_S  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics via 64-bit products of extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0:    begin p = ua * ub; return p[31:0];  end
            2'd1:    begin p = sa * sb; return p[63:32]; end
            2'd2:    begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        return ((a == 32'd0) || (b == 32'd0)) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present an op while IDLE; returns #1 after the accepting edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.OpCode_SI = op;
        bus.OpA_DI    = a;
        bus.OpB_DI    = b;
        bus.InVld_SI  = 1'b1;
        @(posedge clk);
        #1;
        bus.InVld_SI  = 1'b0;
    endtask

    // Wait (bounded) for OutVld; lat counts the accept cycle as 1.
    task automatic wait_result(output logic [31:0] res, output int lat, output bit rdyBad, output bit tmo);
        lat    = 1;
        rdyBad = 1'b0;
        tmo    = 1'b0;
        while ((bus.OutVld_SO !== 1'b1) && (lat < 60)) begin
            if (bus.InRdy_SO !== 1'b0) rdyBad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.OutVld_SO !== 1'b1) tmo = 1'b1;
        if (bus.InRdy_SO !== 1'b0) rdyBad = 1'b1;
        res = bus.Res_DO;
    endtask

    task automatic consume();
        bus.OutRdy_SI = 1'b1;
        @(posedge clk);
        #1;
        bus.OutRdy_SI = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.InRdy_SO !== 1'b1) begin failures++; $display("FAIL reset_inrdy: got %b expected 1", bus.InRdy_SO); end
        checks++;
        if (bus.OutVld_SO !== 1'b0) begin failures++; $display("FAIL reset_outvld: got %b expected 0", bus.OutVld_SO); end
        checks++;
        if (bus.Res_DO !== 32'd0) begin failures++; $display("FAIL reset_res: got %h expected 00000000", bus.Res_DO); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul_basic();
        logic [31:0] res; int lat; bit rdyBad, tmo;
        start_op(2'd0, 32'd7, 32'd6);
        wait_result(res, lat, rdyBad, tmo);
        checks++;
        if (tmo || res !== 32'h0000_002A) begin failures++; $display("FAIL mul_7x6: got %h expected 0000002a timeout=%0d", res, tmo); end
        checks++;
        if (lat != 33) begin failures++; $display("FAIL mul_7x6_latency: got %0d expected 33", lat); end
        checks++;
        if (rdyBad) begin failures++; $display("FAIL mul_7x6_inrdy: got InRdy high while busy expected low"); end
        consume();
        checks++;
        if (bus.InRdy_SO !== 1'b1 || bus.OutVld_SO !== 1'b0) begin
            failures++; $display("FAIL mul_7x6_return_idle: got InRdy=%b OutVld=%b expected 1/0", bus.InRdy_SO, bus.OutVld_SO);
        end
    endtask

    task automatic test_corners();
        logic [1:0]  ops  [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
        logic [31:0] as   [4] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [4] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res; int lat; bit rdyBad, tmo;
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], as[i], bs[i]);
            wait_result(res, lat, rdyBad, tmo);
            checks++;
            if (tmo || res !== exps[i]) begin
                failures++; $display("FAIL corner_%0d op=%0d: got %h expected %h timeout=%0d", i, ops[i], res, exps[i], tmo);
            end
            checks++;
            if (lat != 33) begin failures++; $display("FAIL corner_%0d_latency: got %0d expected 33", i, lat); end
            consume();
        end
    endtask

    task automatic test_zero();
        logic [31:0] res; int lat; bit rdyBad, tmo;
        logic [31:0] a, b; logic [1:0] op;
        for (int i = 0; i < 4; i++) begin
            op = 2'(i);
            a  = (i % 2 == 0) ? 32'd0 : ($urandom | 32'd1);
            b  = (i % 2 == 0) ? ($urandom | 32'd1) : 32'd0;
            start_op(op, a, b);
            wait_result(res, lat, rdyBad, tmo);
            checks++;
            if (tmo || res !== 32'd0) begin failures++; $display("FAIL zero_%0d: got %h expected 00000000", i, res); end
            checks++;
            if (lat != exp_lat(a, b)) begin failures++; $display("FAIL zero_%0d_latency: got %0d expected %0d", i, lat, exp_lat(a, b)); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, held, a2, b2; int lat; bit rdyBad, tmo;
        start_op(2'd3, $urandom | 32'd1, $urandom | 32'd1);
        wait_result(held, lat, rdyBad, tmo);
        checks++;
        if (tmo) begin failures++; $display("FAIL bp_first_result: got timeout expected OutVld"); end
        for (int i = 0; i < 5; i++) begin
            bus.OpCode_SI = 2'd0;
            bus.OpA_DI    = $urandom;
            bus.OpB_DI    = $urandom;
            bus.InVld_SI  = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.OutVld_SO !== 1'b1 || bus.Res_DO !== held || bus.InRdy_SO !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got OutVld=%b Res=%h InRdy=%b expected 1/%h/0", i, bus.OutVld_SO, bus.Res_DO, bus.InRdy_SO, held);
            end
        end
        a2 = $urandom | 32'd1;
        b2 = $urandom | 32'd1;
        bus.OpCode_SI = 2'd1;
        bus.OpA_DI    = a2;
        bus.OpB_DI    = b2;
        bus.InVld_SI  = 1'b1;
        bus.OutRdy_SI = 1'b1;
        @(posedge clk);
        #1;
        bus.OutRdy_SI = 1'b0;
        checks++;
        if (bus.InRdy_SO !== 1'b1 || bus.OutVld_SO !== 1'b0) begin
            failures++; $display("FAIL bp_handshake_edge: got InRdy=%b OutVld=%b expected 1/0", bus.InRdy_SO, bus.OutVld_SO);
        end
        @(posedge clk);
        #1;
        bus.InVld_SI = 1'b0;
        checks++;
        if (bus.InRdy_SO !== 1'b0) begin failures++; $display("FAIL bp_next_accept: got InRdy=%b expected 0", bus.InRdy_SO); end
        wait_result(res, lat, rdyBad, tmo);
        checks++;
        if (tmo || res !== ref_mul(2'd1, a2, b2)) begin
            failures++; $display("FAIL bp_next_result: got %h expected %h", res, ref_mul(2'd1, a2, b2));
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat; bit rdyBad, tmo; bit sawVld;
        start_op(2'd0, $urandom | 32'd1, $urandom | 32'd1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.InRdy_SO !== 1'b1 || bus.OutVld_SO !== 1'b0 || bus.Res_DO !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_state: got InRdy=%b OutVld=%b Res=%h expected 1/0/00000000", bus.InRdy_SO, bus.OutVld_SO, bus.Res_DO);
        end
        sawVld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.OutVld_SO !== 1'b0) sawVld = 1'b1;
        end
        checks++;
        if (sawVld) begin failures++; $display("FAIL rst_mid_dropped: got OutVld high expected op dropped"); end
        start_op(2'd0, 32'd3, 32'd5);
        wait_result(res, lat, rdyBad, tmo);
        checks++;
        if (tmo || res !== 32'h0000_000F) begin failures++; $display("FAIL rst_mid_3x5: got %h expected 0000000f", res); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; logic [1:0] op;
        int hits[$];
        int cyc;
        a  = $urandom | 32'd1;
        b  = $urandom | 32'd1;
        op = 2'($urandom_range(0, 3));
        bus.OpCode_SI = op;
        bus.OpA_DI    = a;
        bus.OpB_DI    = b;
        bus.InVld_SI  = 1'b1;
        bus.OutRdy_SI = 1'b1;
        cyc = 0;
        while (hits.size() < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.OutVld_SO === 1'b1) begin
                hits.push_back(cyc);
                checks++;
                if (bus.Res_DO !== ref_mul(op, a, b)) begin
                    failures++; $display("FAIL b2b_result: got %h expected %h", bus.Res_DO, ref_mul(op, a, b));
                end
                if (hits.size() == 3) bus.InVld_SI = 1'b0;
            end
        end
        bus.InVld_SI = 1'b0;
        @(posedge clk);
        #1;
        bus.OutRdy_SI = 1'b0;
        checks++;
        if (hits.size() != 3) begin
            failures++; $display("FAIL b2b_count: got %0d results expected 3", hits.size());
        end else begin
            checks++;
            if ((hits[1] - hits[0]) != 34 || (hits[2] - hits[1]) != 34) begin
                failures++; $display("FAIL b2b_period: got %0d,%0d expected 34,34", hits[1] - hits[0], hits[2] - hits[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b; logic [1:0] op; int lat; bit rdyBad, tmo;
        for (int n = 0; n < 500; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            start_op(op, a, b);
            wait_result(res, lat, rdyBad, tmo);
            checks++;
            if (tmo || res !== ref_mul(op, a, b)) begin
                failures++; $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h expected %h", n, op, a, b, res, ref_mul(op, a, b));
            end
            checks++;
            if (lat != exp_lat(a, b) || rdyBad) begin
                failures++; $display("FAIL rand_%0d_timing: got lat=%0d inrdy_bad=%0d expected lat=%0d", n, lat, rdyBad, exp_lat(a, b));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            consume();
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.OpA_DI    = 32'd0;
        bus.OpB_DI    = 32'd0;
        bus.OpCode_SI = 2'd0;
        bus.InVld_SI  = 1'b0;
        bus.OutRdy_SI = 1'b0;
        test_reset();
        test_mul_basic();
        test_corners();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_riscv_alu_mult_serial
